os_yanit_birimi: RTL and testbench

FPU response unit for the execute stage. Accepts results from the CVFPU output handshake and pairs each one with the destination metadata captured at issue. It presents one ordered writeback per result to the integer or FP register file and accumulates exception status into `fflags`. It also discards results that are still in flight when a pipeline flush occurs.

---
 rtl/os_yanit_birimi_pkg.sv | 53 +++++
 rtl/os_yanit_birimi_if.sv | 25 ++
 rtl/os_meta_fifo.sv | 68 ++++++
 rtl/os_yanit_birimi.sv | 163 ++++++++++++++++
 tb/tb_os_yanit_birimi.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/os_yanit_birimi_pkg.sv
// Shared types and decode helpers for the FPU response unit.
// Operation encoding, fflags/status types and the metadata entry layout.
package os_yanit_birimi_pkg;

  typedef enum logic [4:0] {
    OS_FADD, OS_FSUB, OS_FMUL, OS_FDIV, OS_FSQRT, OS_FMADD, OS_FMIN,
    OS_FMAX, OS_FSGNJ, OS_FCVT_W_S, OS_FCVT_WU_S, OS_FCVT_S_W,
    OS_FCVT_S_WU, OS_FMV_X, OS_FMV_W, OS_FEQ, OS_FLT, OS_FLE,
    OS_FCLASS, OS_FLW, OS_FSW
  } os_islem_t;

  typedef logic [4:0] fflags_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       tamsayi;
  } meta_t;

  localparam int META_W = 6;

  function automatic logic os_hedef_tamsayi(os_islem_t islem);
    logic sonuc;
    case (islem)
      OS_FCVT_W_S, OS_FCVT_WU_S, OS_FMV_X,
      OS_FEQ, OS_FLT, OS_FLE, OS_FCLASS: sonuc = 1'b1;
      default:                           sonuc = 1'b0;
    endcase
    return sonuc;
  endfunction

  // Loads and stores bypass the CVFPU, so they never produce a result here.
  function automatic logic os_cv_kullanir(os_islem_t islem);
    logic sonuc;
    case (islem)
      OS_FLW, OS_FSW: sonuc = 1'b0;
      default:        sonuc = 1'b1;
    endcase
    return sonuc;
  endfunction

  function automatic fflags_t durum_to_fflags(status_t durum);
    return {durum.nv, durum.dz, durum.of, durum.uf, durum.nx};
  endfunction

endpackage

// File: rtl/os_yanit_birimi_if.sv
// CVFPU result channel and register-file writeback channel.
// slave is the response unit, master is its environment.
interface os_yanit_birimi_if #(
  parameter int XLEN = 32
);
  logic            cv_gecerli_i;
  logic            cv_hazir_o;
  logic [XLEN-1:0] cv_sonuc_i;
  logic [4:0]      cv_durum_i;
  logic            gy_gecerli_o;
  logic            gy_hazir_i;
  logic [4:0]      gy_rd_o;
  logic [XLEN-1:0] gy_veri_o;
  logic            gy_tamsayi_o;

  modport slave (
    input  cv_gecerli_i, cv_sonuc_i, cv_durum_i, gy_hazir_i,
    output cv_hazir_o, gy_gecerli_o, gy_rd_o, gy_veri_o, gy_tamsayi_o
  );

  modport master (
    output cv_gecerli_i, cv_sonuc_i, cv_durum_i, gy_hazir_i,
    input  cv_hazir_o, gy_gecerli_o, gy_rd_o, gy_veri_o, gy_tamsayi_o
  );
endinterface

// File: rtl/os_meta_fifo.sv
// Synchronous FIFO for issue-time destination metadata.
// Writes into a full FIFO are ignored even when a read happens in the same cycle.
module os_meta_fifo #(
  parameter int DERINLIK = 4,
  parameter int GENISLIK = 6,
  localparam int PW = $clog2(DERINLIK),
  localparam int SW = $clog2(DERINLIK + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                temizle_i,
  input  logic                yaz_i,
  input  logic                oku_i,
  input  logic [GENISLIK-1:0] veri_i,
  output logic [GENISLIK-1:0] veri_o,
  output logic                dolu_o,
  output logic                bos_o,
  output logic [SW-1:0]       sayi_o
);

  logic [GENISLIK-1:0] r_mem [DERINLIK];
  logic [PW-1:0]       r_yaz_ptr;
  logic [PW-1:0]       r_oku_ptr;
  logic [SW-1:0]       r_sayi;
  logic                w_dolu;
  logic                w_bos;
  logic                w_yaz;
  logic                w_oku;

  assign w_dolu = (r_sayi == SW'(DERINLIK));
  assign w_bos  = (r_sayi == {SW{1'b0}});
  assign w_yaz  = yaz_i & ~w_dolu & ~temizle_i;
  assign w_oku  = oku_i & ~w_bos & ~temizle_i;

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (w_yaz) begin
      r_mem[r_yaz_ptr] <= veri_i;
    end
  end

  // Pointers and occupancy; a flush empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i || temizle_i) begin
      r_yaz_ptr <= {PW{1'b0}};
      r_oku_ptr <= {PW{1'b0}};
      r_sayi    <= {SW{1'b0}};
    end else begin
      if (w_yaz) begin
        r_yaz_ptr <= r_yaz_ptr + PW'(1);
      end
      if (w_oku) begin
        r_oku_ptr <= r_oku_ptr + PW'(1);
      end
      case ({w_yaz, w_oku})
        2'b10:   r_sayi <= r_sayi + SW'(1);
        2'b01:   r_sayi <= r_sayi - SW'(1);
        default: r_sayi <= r_sayi;
      endcase
    end
  end

  assign veri_o = r_mem[r_oku_ptr];
  assign dolu_o = w_dolu;
  assign bos_o  = w_bos;
  assign sayi_o = r_sayi;

endmodule

// File: rtl/os_yanit_birimi.sv
// FPU response unit: pairs CVFPU results with issue metadata, presents ordered
// writebacks, accumulates fflags and discards results orphaned by a flush.
module os_yanit_birimi
  import os_yanit_birimi_pkg::*;
#(
  parameter int DERINLIK = 4,
  parameter int XLEN     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              istek_gecerli_i,
  input  os_islem_t         istek_islem_i,
  input  logic [4:0]        istek_rd_i,
  output logic              dolu_o,
  os_yanit_birimi_if.slave  yb,
  input  logic              temizle_i,
  input  logic              fflags_yaz_i,
  input  fflags_t           fflags_veri_i,
  output fflags_t           fflags_o,
  output logic              mesgul_o,
  output logic              hata_o
);

  localparam int SW = $clog2(DERINLIK + 1);

  logic [SW-1:0]   w_sayi;
  logic            w_dolu;
  logic            w_bos;
  meta_t           w_meta_yaz;
  meta_t           w_meta_oku;
  logic            w_push;
  logic            w_atilacak_var;
  logic            w_cv_hazir;
  logic            w_cv_hs;
  logic            w_gy_hs;
  logic            w_at;
  logic            w_pop;
  logic            w_yetim;
  logic [SW:0]     w_toplam;
  logic [SW:0]     w_flush_fark;
  logic [SW-1:0]   w_atilacak_sonraki;
  fflags_t         w_fflags_taban;
  fflags_t         w_fflags_sonraki;

  logic [SW-1:0]   r_atilacak;
  logic            r_gecerli;
  logic [4:0]      r_rd;
  logic            r_tamsayi;
  logic [XLEN-1:0] r_veri;
  fflags_t         r_durum;
  fflags_t         r_fflags;
  logic            r_hata;

  assign w_meta_yaz = '{rd: istek_rd_i, tamsayi: os_hedef_tamsayi(istek_islem_i)};
  assign w_push     = istek_gecerli_i & os_cv_kullanir(istek_islem_i) & ~temizle_i;

  os_meta_fifo #(
    .DERINLIK (DERINLIK),
    .GENISLIK (META_W)
  ) u_meta_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .temizle_i (temizle_i),
    .yaz_i     (w_push),
    .oku_i     (w_pop),
    .veri_i    (w_meta_yaz),
    .veri_o    (w_meta_oku),
    .dolu_o    (w_dolu),
    .bos_o     (w_bos),
    .sayi_o    (w_sayi)
  );

  assign w_atilacak_var = (r_atilacak != {SW{1'b0}});
  assign w_cv_hazir     = w_atilacak_var | ~r_gecerli | yb.gy_hazir_i;
  assign w_cv_hs        = yb.cv_gecerli_i & w_cv_hazir;
  assign w_gy_hs        = r_gecerli & yb.gy_hazir_i;
  assign w_at           = w_cv_hs & w_atilacak_var;
  assign w_pop          = w_cv_hs & ~w_atilacak_var & ~w_bos & ~temizle_i;
  assign w_yetim        = w_cv_hs & ~w_atilacak_var & w_bos & ~temizle_i;
  assign w_toplam       = {1'b0, w_sayi} + {1'b0, r_atilacak};

  // Everything queued or already owed becomes owed, minus a result consumed now.
  always_comb begin
    w_flush_fark = w_toplam;
    if (w_cv_hs && (w_toplam != {(SW+1){1'b0}})) begin
      w_flush_fark = w_toplam - (SW+1)'(1);
    end else begin
      w_flush_fark = w_toplam;
    end
  end

  // Discard counter next state.
  always_comb begin
    w_atilacak_sonraki = r_atilacak;
    if (temizle_i) begin
      if (w_flush_fark > (SW+1)'(DERINLIK)) begin
        w_atilacak_sonraki = SW'(DERINLIK);
      end else begin
        w_atilacak_sonraki = w_flush_fark[SW-1:0];
      end
    end else if (w_at) begin
      w_atilacak_sonraki = r_atilacak - SW'(1);
    end else begin
      w_atilacak_sonraki = r_atilacak;
    end
  end

  // Status is only accumulated when a writeback is actually accepted.
  always_comb begin
    w_fflags_taban   = fflags_yaz_i ? fflags_veri_i : r_fflags;
    w_fflags_sonraki = w_fflags_taban;
    if (w_gy_hs && !temizle_i) begin
      w_fflags_sonraki = w_fflags_taban | r_durum;
    end else begin
      w_fflags_sonraki = w_fflags_taban;
    end
  end

  // Discard counter, fflags and error pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_atilacak <= {SW{1'b0}};
      r_fflags   <= 5'b00000;
      r_hata     <= 1'b0;
    end else begin
      r_atilacak <= w_atilacak_sonraki;
      r_fflags   <= w_fflags_sonraki;
      r_hata     <= w_yetim;
    end
  end

  // Single-entry writeback register; a new load may coincide with acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gecerli <= 1'b0;
      r_rd      <= 5'b00000;
      r_tamsayi <= 1'b0;
      r_veri    <= {XLEN{1'b0}};
      r_durum   <= 5'b00000;
    end else if (temizle_i) begin
      r_gecerli <= 1'b0;
    end else if (w_pop) begin
      r_gecerli <= 1'b1;
      r_rd      <= w_meta_oku.rd;
      r_tamsayi <= w_meta_oku.tamsayi;
      r_veri    <= yb.cv_sonuc_i;
      r_durum   <= durum_to_fflags(status_t'(yb.cv_durum_i));
    end else if (w_gy_hs) begin
      r_gecerli <= 1'b0;
    end
  end

  assign yb.cv_hazir_o   = w_cv_hazir;
  assign yb.gy_gecerli_o = r_gecerli;
  assign yb.gy_rd_o      = r_rd;
  assign yb.gy_veri_o    = r_veri;
  assign yb.gy_tamsayi_o = r_tamsayi;
  assign dolu_o          = w_dolu;
  assign fflags_o        = r_fflags;
  assign hata_o          = r_hata;
  assign mesgul_o        = (w_sayi != {SW{1'b0}}) | w_atilacak_var | r_gecerli;

endmodule

// File: tb/tb_os_yanit_birimi.sv
// Randomized and directed bench for os_yanit_birimi against a queue-based reference model.
module tb_os_yanit_birimi;
  import os_yanit_birimi_pkg::*;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       istek_gecerli;
  os_islem_t  istek_islem;
  logic [4:0] istek_rd;
  logic       dolu;
  logic       temizle;
  logic       fflags_yaz;
  logic [4:0] fflags_veri;
  logic [4:0] fflags;
  logic       mesgul;
  logic       hata;

  os_yanit_birimi_if #(.XLEN(32)) u_if ();

  os_yanit_birimi #(.DERINLIK(D), .XLEN(32)) u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .istek_gecerli_i (istek_gecerli),
    .istek_islem_i   (istek_islem),
    .istek_rd_i      (istek_rd),
    .dolu_o          (dolu),
    .yb              (u_if),
    .temizle_i       (temizle),
    .fflags_yaz_i    (fflags_yaz),
    .fflags_veri_i   (fflags_veri),
    .fflags_o        (fflags),
    .mesgul_o        (mesgul),
    .hata_o          (hata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rd;
    bit         tam;
  } m_t;

  m_t          q[$];
  int          atil;
  bit          out_v;
  logic [4:0]  out_rd;
  logic [31:0] out_veri;
  bit          out_tam;
  logic [4:0]  out_durum;
  logic [4:0]  m_flags;
  bit          m_hata;
  int          n_kontrol;
  int          n_gecen;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    n_kontrol++;
    if (gozlenen === beklenen) n_gecen++;
    else $display("FAIL %s: gozlenen=%0h beklenen=%0h (t=%0t)", etiket, gozlenen, beklenen, $time);
  endtask

  function automatic bit hedef_ref(os_islem_t op);
    return op inside {OS_FCVT_W_S, OS_FCVT_WU_S, OS_FMV_X, OS_FEQ, OS_FLT, OS_FLE, OS_FCLASS};
  endfunction

  task automatic model_sifirla();
    q.delete();
    atil = 0; out_v = 0; out_rd = 5'd0; out_veri = 32'd0; out_tam = 0;
    out_durum = 5'd0; m_flags = 5'd0; m_hata = 0;
  endtask

  task automatic sifirla();
    @(negedge clk);
    rst = 1'b1; istek_gecerli = 1'b0; istek_islem = OS_FADD; istek_rd = 5'd0;
    u_if.cv_gecerli_i = 1'b0; u_if.cv_sonuc_i = 32'd0; u_if.cv_durum_i = 5'd0;
    u_if.gy_hazir_i = 1'b0; temizle = 1'b0; fflags_yaz = 1'b0; fflags_veri = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_sifirla();
  endtask

  // One clock: drive inputs, compare all outputs with the model, advance the model.
  task automatic adim(input bit iv, input os_islem_t op, input logic [4:0] rd,
                      input bit cv, input logic [31:0] sonuc, input logic [4:0] durum,
                      input bit gh, input bit tem, input bit fy, input logic [4:0] fv);
    bit hz, hs, gyhs, yuklendi, full;
    m_t m;
    @(negedge clk);
    istek_gecerli = iv; istek_islem = op; istek_rd = rd;
    u_if.cv_gecerli_i = cv; u_if.cv_sonuc_i = sonuc; u_if.cv_durum_i = durum;
    u_if.gy_hazir_i = gh; temizle = tem; fflags_yaz = fy; fflags_veri = fv;
    #1;
    hz = (atil != 0) || !out_v || gh;
    kontrol("cv_hazir", 32'(u_if.cv_hazir_o), 32'(hz));
    kontrol("gy_gecerli", 32'(u_if.gy_gecerli_o), 32'(out_v));
    if (out_v) begin
      kontrol("gy_rd", 32'(u_if.gy_rd_o), 32'(out_rd));
      kontrol("gy_veri", u_if.gy_veri_o, out_veri);
      kontrol("gy_tamsayi", 32'(u_if.gy_tamsayi_o), 32'(out_tam));
    end
    kontrol("fflags", 32'(fflags), 32'(m_flags));
    kontrol("hata", 32'(hata), 32'(m_hata));
    kontrol("dolu", 32'(dolu), 32'(q.size() == D));
    kontrol("mesgul", 32'(mesgul), 32'(q.size() != 0 || atil != 0 || out_v));

    hs   = cv && hz;
    gyhs = out_v && gh;
    full = (q.size() >= D);
    m_flags = (fy ? fv : m_flags) | ((gyhs && !tem) ? out_durum : 5'd0);
    m_hata  = 0;
    if (tem) begin
      atil = q.size() + atil - (hs ? 1 : 0);
      if (atil < 0) atil = 0;
      if (atil > D) atil = D;
      q.delete();
      out_v = 0;
    end else begin
      yuklendi = 0;
      if (hs) begin
        if (atil > 0) atil--;
        else if (q.size() > 0) begin
          m = q.pop_front();
          out_rd = m.rd; out_tam = m.tam; out_veri = sonuc; out_durum = durum;
          yuklendi = 1;
        end else m_hata = 1;
      end
      if (yuklendi) out_v = 1;
      else if (gyhs) out_v = 0;
      if (iv && !(op inside {OS_FLW, OS_FSW}) && !full) q.push_back('{rd, hedef_ref(op)});
    end
    @(posedge clk);
  endtask

  task automatic bos_adim(input bit gh);
    adim(0, OS_FADD, 5'd0, 0, 32'd0, 5'd0, gh, 0, 0, 5'd0);
  endtask

  initial begin
    n_kontrol = 0; n_gecen = 0;
    sifirla();

    // Reset state
    #1;
    kontrol("rst_gecerli", 32'(u_if.gy_gecerli_o), 32'd0);
    kontrol("rst_fflags", 32'(fflags), 32'd0);
    kontrol("rst_hata", 32'(hata), 32'd0);
    kontrol("rst_dolu", 32'(dolu), 32'd0);
    kontrol("rst_mesgul", 32'(mesgul), 32'd0);
    kontrol("rst_cv_hazir", 32'(u_if.cv_hazir_o), 32'd1);
    kontrol("rst_rd", 32'(u_if.gy_rd_o), 32'd0);
    kontrol("rst_veri", u_if.gy_veri_o, 32'd0);
    kontrol("rst_tamsayi", 32'(u_if.gy_tamsayi_o), 32'd0);

    // Single result
    adim(1, OS_FADD, 5'd5, 0, 32'd0, 5'd0, 1, 0, 0, 5'd0);
    adim(0, OS_FADD, 5'd0, 1, 32'h40400000, 5'b00001, 0, 0, 0, 5'd0);
    #1;
    kontrol("tek_gecerli", 32'(u_if.gy_gecerli_o), 32'd1);
    kontrol("tek_rd", 32'(u_if.gy_rd_o), 32'd5);
    kontrol("tek_tamsayi", 32'(u_if.gy_tamsayi_o), 32'd0);
    kontrol("tek_veri", u_if.gy_veri_o, 32'h40400000);
    bos_adim(1);
    #1 kontrol("tek_fflags", 32'(fflags), 32'h01);

    // Integer destination
    adim(1, OS_FEQ, 5'd10, 0, 32'd0, 5'd0, 1, 0, 0, 5'd0);
    adim(0, OS_FADD, 5'd0, 1, 32'd1, 5'd0, 0, 0, 0, 5'd0);
    #1;
    kontrol("tam_tamsayi", 32'(u_if.gy_tamsayi_o), 32'd1);
    kontrol("tam_rd", 32'(u_if.gy_rd_o), 32'd10);
    bos_adim(1);

    // Full and backpressure
    for (int i = 0; i < 4; i++) adim(1, OS_FADD, 5'(i + 1), 0, 32'd0, 5'd0, 1, 0, 0, 5'd0);
    #1 kontrol("dolu_4", 32'(dolu), 32'd1);
    adim(1, OS_FSUB, 5'd9, 0, 32'd0, 5'd0, 1, 0, 0, 5'd0);
    #1 kontrol("dolu_5", 32'(dolu), 32'd1);
    adim(0, OS_FADD, 5'd0, 1, 32'h100, 5'd0, 0, 0, 0, 5'd0);
    adim(0, OS_FADD, 5'd0, 1, 32'h200, 5'd0, 0, 0, 0, 5'd0);
    #1;
    kontrol("bp_hazir", 32'(u_if.cv_hazir_o), 32'd0);
    kontrol("bp_rd", 32'(u_if.gy_rd_o), 32'd1);
    kontrol("bp_veri", u_if.gy_veri_o, 32'h100);
    adim(0, OS_FADD, 5'd0, 1, 32'h200, 5'd0, 1, 0, 0, 5'd0);
    #1;
    kontrol("bp_sira_rd", 32'(u_if.gy_rd_o), 32'd2);
    kontrol("bp_sira_veri", u_if.gy_veri_o, 32'h200);
    adim(0, OS_FADD, 5'd0, 1, 32'h300, 5'd0, 1, 0, 0, 5'd0);
    adim(0, OS_FADD, 5'd0, 1, 32'h400, 5'd0, 1, 0, 0, 5'd0);
    #1 kontrol("bp_son_rd", 32'(u_if.gy_rd_o), 32'd4);
    bos_adim(1);

    // Flush with two results still owed
    adim(1, OS_FMUL, 5'd11, 0, 32'd0, 5'd0, 1, 0, 1, 5'd0);
    adim(1, OS_FMUL, 5'd12, 0, 32'd0, 5'd0, 1, 0, 0, 5'd0);
    adim(1, OS_FMUL, 5'd13, 0, 32'd0, 5'd0, 1, 0, 0, 5'd0);
    adim(0, OS_FADD, 5'd0, 1, 32'hA, 5'b10000, 0, 0, 0, 5'd0);
    adim(0, OS_FADD, 5'd0, 0, 32'd0, 5'd0, 0, 1, 0, 5'd0);
    #1 kontrol("fl_gecerli", 32'(u_if.gy_gecerli_o), 32'd0);
    adim(0, OS_FADD, 5'd0, 1, 32'hB, 5'b11111, 1, 0, 0, 5'd0);
    adim(0, OS_FADD, 5'd0, 1, 32'hC, 5'b11111, 1, 0, 0, 5'd0);
    #1;
    kontrol("fl_atil_gecerli", 32'(u_if.gy_gecerli_o), 32'd0);
    kontrol("fl_atil_fflags", 32'(fflags), 32'd0);
    kontrol("fl_mesgul", 32'(mesgul), 32'd0);
    adim(1, OS_FADD, 5'd20, 0, 32'd0, 5'd0, 1, 0, 0, 5'd0);
    adim(0, OS_FADD, 5'd0, 1, 32'h77, 5'b00010, 0, 0, 0, 5'd0);
    #1;
    kontrol("fl_sonra_rd", 32'(u_if.gy_rd_o), 32'd20);
    kontrol("fl_sonra_veri", u_if.gy_veri_o, 32'h77);
    bos_adim(1);
    #1 kontrol("fl_sonra_fflags", 32'(fflags), 32'h02);

    // CSR write coinciding with accumulation
    adim(0, OS_FADD, 5'd0, 0, 32'd0, 5'd0, 1, 0, 1, 5'h01);
    adim(1, OS_FDIV, 5'd3, 0, 32'd0, 5'd0, 1, 0, 0, 5'd0);
    adim(0, OS_FADD, 5'd0, 1, 32'h3F800000, 5'b01000, 0, 0, 0, 5'd0);
    #1 kontrol("csr_once", 32'(fflags), 32'h01);
    adim(0, OS_FADD, 5'd0, 0, 32'd0, 5'd0, 1, 0, 1, 5'h00);
    #1 kontrol("csr_birikim", 32'(fflags), 32'h08);

    // Orphan result
    adim(0, OS_FADD, 5'd0, 1, 32'h5, 5'b11111, 1, 0, 0, 5'd0);
    #1;
    kontrol("yetim_hata", 32'(hata), 32'd1);
    kontrol("yetim_gecerli", 32'(u_if.gy_gecerli_o), 32'd0);
    bos_adim(1);
    #1 kontrol("yetim_darbe", 32'(hata), 32'd0);

    // Randomized traffic with a mid-run reset
    for (int n = 0; n < 800; n++) begin
      int  inflight;
      bit  cv, iv;
      if (n == 400) sifirla();
      inflight = q.size() + atil;
      cv = (inflight > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      iv = ($urandom_range(0, 2) == 0) && (inflight < D) && !(cv && q.size() == 0 && atil == 0);
      adim(iv, os_islem_t'(5'($urandom_range(0, 20))), 5'($urandom_range(0, 31)),
           cv, $urandom, 5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 11) == 0), 5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_gecen, n_kontrol);
    $finish;
  end

endmodule
